// File: rtl/display_pkg.sv
// Shared constants for the 3-digit multiplexed display: segment codes and scan slot indices.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} codes, indexed by hex digit value
  localparam logic [15:0][6:0] SEG_CODES = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [1:0] SLOT_U   = 2'd0;
  localparam logic [1:0] SLOT_D   = 2'd1;
  localparam logic [1:0] SLOT_C   = 2'd2;
  localparam logic [1:0] SLOT_OFF = 2'd3;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to active-low 7-segment decoder.
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_CODES[i_digit];

endmodule

// File: rtl/display_mux_3dig.sv
// Latches a units/tens/hundreds triple and scans it onto a 4-anode common-anode display.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_mux_3dig
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cargar,
  input  logic [3:0] unidad,
  input  logic [3:0] decena,
  input  logic [3:0] centena,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] slot
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_slot;
  logic          r_primed;
  logic          r_blank;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic [3:0]    r_u, r_d, r_c;

  logic [CW-1:0] w_cnt_next;
  logic          w_wrap;
  logic [1:0]    w_slot_next;
  logic [3:0]    w_digit;
  logic [6:0]    w_dec;
  logic          w_lz;
  logic          w_blank_new;
  logic          w_blank;
  logic [3:0]    w_an_next;

  assign w_wrap = (r_cnt == CW'(REFRESH_DIV - 1));

  always_comb begin
    w_cnt_next  = w_wrap ? '0 : r_cnt + 1'b1;
    // The first wrap after reset only arms the scan; slot 0 is then shown for real
    w_slot_next = (w_wrap && r_primed) ? r_slot + 2'd1 : r_slot;
    unique case (w_slot_next)
      SLOT_U:  w_digit = r_u;
      SLOT_D:  w_digit = r_d;
      SLOT_C:  w_digit = r_c;
      default: w_digit = 4'd0;
    endcase
  end

  hex_to_7seg u_dec (
    .i_digit (w_digit),
    .o_seg   (w_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign w_lz = ((w_slot_next == SLOT_C) && (r_c == 4'd0)) ||
                ((w_slot_next == SLOT_D) && (r_c == 4'd0) && (r_d == 4'd0));
`else
  assign w_lz = 1'b0;
`endif

  assign w_blank_new = (w_slot_next == SLOT_OFF) || w_lz;
  assign w_blank     = w_wrap ? w_blank_new : r_blank;
  assign w_an_next   = (w_blank || (32'(w_cnt_next) < BLANK_CYC)) ? 4'b1111
                                                                  : ~(4'b0001 << w_slot_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_slot   <= SLOT_U;
      r_primed <= 1'b0;
      r_blank  <= 1'b1;
      r_seg    <= SEG_BLANK;
      r_an     <= 4'b1111;
      r_u      <= 4'd0;
      r_d      <= 4'd0;
      r_c      <= 4'd0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_slot <= w_slot_next;
      r_an   <= w_an_next;
      if (w_wrap) begin
        r_primed <= 1'b1;
        r_blank  <= w_blank_new;
        r_seg    <= w_blank_new ? SEG_BLANK : w_dec;
      end
      // Loaded after the decode above, so a same-edge load shows from the next slot
      if (cargar) begin
        r_u <= unidad;
        r_d <= decena;
        r_c <= centena;
      end
    end
  end

  assign an   = r_an;
  assign seg  = r_seg;
  assign dp   = 1'b1;
  assign slot = r_slot;

endmodule

// File: tb/tb_display_mux_3dig.sv
// Self-checking bench for display_mux_3dig: edge-count reference model plus directed literal pins.
module tb_display_mux_3dig;

  localparam int DIV = 8;
  localparam int BLK = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cargar = 1'b0;
  logic [3:0] unidad = 4'd0, decena = 4'd0, centena = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] slot;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  display_mux_3dig #(.REFRESH_DIV(DIV), .BLANK_CYC(BLK)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cargar  (cargar),
    .unidad  (unidad),
    .decena  (decena),
    .centena (centena),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .slot    (slot)
  );

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  // Time since reset release, in clock edges; the first DIV edges are a dark priming period
  function automatic int slot_of(input int e);
    return (e < DIV) ? 0 : ((e - DIV) / DIV) % 4;
  endfunction

  function automatic int pos_of(input int e);
    return (e < DIV) ? e : (e - DIV) % DIV;
  endfunction

  function automatic bit lz(input int s, input logic [3:0] c, input logic [3:0] d);
    return LZB && ((s == 2 && c == 4'd0) || (s == 1 && c == 4'd0 && d == 4'd0));
  endfunction

  int         m_e;
  logic [3:0] m_u, m_d, m_c;
  logic [6:0] m_seg;
  logic       m_blank;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e <= 0; m_u <= 4'd0; m_d <= 4'd0; m_c <= 4'd0;
      m_seg <= 7'h7F; m_blank <= 1'b1;
    end else begin
      m_e <= m_e + 1;
      if (m_e + 1 >= DIV && pos_of(m_e + 1) == 0) begin
        if (slot_of(m_e + 1) == 3 || lz(slot_of(m_e + 1), m_c, m_d)) begin
          m_seg <= 7'h7F; m_blank <= 1'b1;
        end else begin
          m_seg   <= dec(slot_of(m_e + 1) == 0 ? m_u : slot_of(m_e + 1) == 1 ? m_d : m_c);
          m_blank <= 1'b0;
        end
      end
      if (cargar) begin
        m_u <= unidad; m_d <= decena; m_c <= centena;
      end
    end
  end

  function automatic logic [3:0] exp_an(input int e, input logic blank);
    if (blank || pos_of(e) < BLK) return 4'hF;
    return ~(4'b0001 << slot_of(e));
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input logic [6:0] act, input logic [6:0] model,
                     input logic [6:0] lit);
    chk(name, act, lit);
    chk({name, "_model"}, model, lit);
  endtask

  always @(negedge clk) begin
    chk("an", {3'b0, an}, {3'b0, exp_an(m_e, m_blank)});
    chk("seg", seg, m_seg);
    chk("slot", {5'b0, slot}, 7'(slot_of(m_e)));
    chk("dp", {6'b0, dp}, 7'd1);
  end

  task automatic wait_pos(input int s, input int p);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (m_e >= DIV && slot_of(m_e) == s && pos_of(m_e) == p) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_pos: slot %0d pos %0d never reached", s, p);
  endtask

  task automatic load(input logic [3:0] u, input logic [3:0] d, input logic [3:0] c);
    #1;
    cargar = 1'b1; unidad = u; decena = d; centena = c;
    @(negedge clk);
    #2;
    cargar = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    pin("rst_an", {3'b0, an}, {3'b0, exp_an(m_e, m_blank)}, 7'h0F);
    pin("rst_seg", seg, m_seg, 7'h7F);
    pin("rst_slot", {5'b0, slot}, 7'(slot_of(m_e)), 7'd0);
    repeat (7) @(negedge clk);
    #1;
    pin("prime_an", {3'b0, an}, {3'b0, exp_an(m_e, m_blank)}, 7'h0F);
    repeat (2) @(negedge clk);
    #1;
    pin("first_blank_an", {3'b0, an}, {3'b0, exp_an(m_e, m_blank)}, 7'h0F);
    @(negedge clk);
    #1;
    pin("first_on_an", {3'b0, an}, {3'b0, exp_an(m_e, m_blank)}, 7'h0E);
    pin("first_on_seg", seg, m_seg, 7'h40);

    load(4'd2, 4'd5, 4'd1);
    wait_pos(0, 3);
    pin("u_seg", seg, m_seg, 7'h24);
    pin("u_an", {3'b0, an}, {3'b0, exp_an(m_e, m_blank)}, 7'h0E);
    wait_pos(1, 3);
    pin("d_seg", seg, m_seg, 7'h12);
    pin("d_an", {3'b0, an}, {3'b0, exp_an(m_e, m_blank)}, 7'h0D);
    wait_pos(2, 3);
    pin("c_seg", seg, m_seg, 7'h79);
    pin("c_an", {3'b0, an}, {3'b0, exp_an(m_e, m_blank)}, 7'h0B);
    wait_pos(3, 3);
    pin("off_seg", seg, m_seg, 7'h7F);
    pin("off_an", {3'b0, an}, {3'b0, exp_an(m_e, m_blank)}, 7'h0F);
    wait_pos(0, 1);
    pin("slot_blank_an", {3'b0, an}, {3'b0, exp_an(m_e, m_blank)}, 7'h0F);

    wait_pos(0, 4);
    load(4'd7, 4'd5, 4'd1);
    wait_pos(0, 7);
    pin("reload_frozen", seg, m_seg, 7'h24);
    wait_pos(0, 3);
    pin("reload_seen", seg, m_seg, 7'h78);

    wait_pos(1, 0);
    load(4'hA, 4'd5, 4'd1);
    wait_pos(0, 3);
    pin("hex_a", seg, m_seg, 7'h08);

    load(4'd7, 4'd0, 4'd0);
    wait_pos(1, 3);
`ifdef LEADING_ZERO_BLANK_EN
    pin("lz_d_seg", seg, m_seg, 7'h7F);
    pin("lz_d_an", {3'b0, an}, {3'b0, exp_an(m_e, m_blank)}, 7'h0F);
`else
    pin("lz_d_seg", seg, m_seg, 7'h40);
    pin("lz_d_an", {3'b0, an}, {3'b0, exp_an(m_e, m_blank)}, 7'h0D);
`endif
    wait_pos(2, 3);
`ifdef LEADING_ZERO_BLANK_EN
    pin("lz_c_seg", seg, m_seg, 7'h7F);
    pin("lz_c_an", {3'b0, an}, {3'b0, exp_an(m_e, m_blank)}, 7'h0F);
`else
    pin("lz_c_seg", seg, m_seg, 7'h40);
    pin("lz_c_an", {3'b0, an}, {3'b0, exp_an(m_e, m_blank)}, 7'h0B);
`endif
    wait_pos(0, 3);
    pin("lz_u_seg", seg, m_seg, 7'h78);

    load(4'd2, 4'd5, 4'd1);
    wait_pos(1, 5);
    #1 rst_n = 1'b0;
    #1;
    pin("midrst_an", {3'b0, an}, {3'b0, exp_an(m_e, m_blank)}, 7'h0F);
    pin("midrst_seg", seg, m_seg, 7'h7F);
    pin("midrst_slot", {5'b0, slot}, 7'(slot_of(m_e)), 7'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_pos(0, 3);
    pin("midrst_cleared", seg, m_seg, 7'h40);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #2;
      cargar  = ($urandom_range(0, 5) == 0);
      unidad  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      decena  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      centena = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if (i == 1500 + int'($urandom_range(0, 40))) begin
        rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    cargar = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
